// File: rtl/hazard_control_unit.sv
// hazard_control_unit: ID-stage decoder and load-use hazard controller.
// Decodes the RV32 opcode held in IF/ID into the ID/EX control register,
// inserts bubbles on load-use hazards, flushes and illegal opcodes, and
// raises a combinational stall that holds IF/ID.
//
// Handshake: the ID/EX register advances only on a rising edge where
// ex_ready=1; with ex_ready=0 the register, state and counter all hold and
// flush is ignored. stall=1 tells the fetch side that the instruction
// currently in IF/ID was not consumed and must be presented again next cycle.
module hazard_control_unit #(
  parameter int ALU_CTRL_W      = 2,
  parameter int LOAD_USE_STALLS = 1,
  parameter int SUPPORT_UJ      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  input  logic [31:0]           instr,
  input  logic                  ex_ready,
  input  logic                  flush,
  output logic                  ex_valid,
  output logic                  mem_read_en,
  output logic                  mem_write_en,
  output logic                  reg_write_en,
  output logic                  branch_flag,
  output logic                  jump_flag,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic [1:0]            mux_a_sel,
  output logic [1:0]            mux_b_sel,
  output logic [1:0]            mux_data_sel,
  output logic [4:0]            rd_out,
  output logic                  stall,
  output logic                  illegal_op,
  output logic                  state_dbg,
  output logic [1:0]            cnt_dbg
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  // Counter preload when entering STALL: the first bubble is inserted by
  // the RUN cycle that detects the hazard, the rest are counted down here.
  localparam logic [1:0] CNT_INIT = 2'(LOAD_USE_STALLS - 1);

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  // Decoded control for the instruction currently in IF/ID.
  typedef struct packed {
    logic       legal;
    logic       use1;
    logic       use2;
    logic       rd_we;
    logic       mem_rd;
    logic       mem_wr;
    logic       br;
    logic       jmp;
    logic [1:0] alu;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] data;
  } dec_t;

  // Contents of the ID/EX control register.
  typedef struct packed {
    logic       valid;
    logic       rd_we;
    logic       mem_rd;
    logic       mem_wr;
    logic       br;
    logic       jmp;
    logic [1:0] alu;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] data;
    logic [4:0] rd;
    logic       illegal;
  } idex_t;

  state_t     state;
  logic [1:0] cnt;
  idex_t      idex;
  idex_t      nxt;
  dec_t       dec;
  logic       hazard;

  logic [6:0] opcode;
  logic [4:0] rd_f;
  logic [4:0] rs1_f;
  logic [4:0] rs2_f;
  logic       unused_bits;

  assign opcode      = instr[6:0];
  assign rd_f        = instr[11:7];
  assign rs1_f       = instr[19:15];
  assign rs2_f       = instr[24:20];
  // funct fields are consumed by the EX stage, not here.
  assign unused_bits = ^{instr[31:25], instr[14:12]};

  // Opcode decode into control fields and source-register usage.
  always_comb begin
    dec = '0;
    case (opcode)
      OP_R: begin
        dec.legal = 1'b1; dec.use1 = 1'b1; dec.use2 = 1'b1;
        dec.rd_we = 1'b1; dec.alu  = 2'b10;
      end
      OP_I: begin
        dec.legal = 1'b1; dec.use1 = 1'b1;
        dec.rd_we = 1'b1; dec.alu  = 2'b11; dec.b = 2'b01;
      end
      OP_LOAD: begin
        dec.legal  = 1'b1; dec.use1 = 1'b1;
        dec.rd_we  = 1'b1; dec.mem_rd = 1'b1;
        dec.b      = 2'b01; dec.data = 2'b01;
      end
      OP_STORE: begin
        dec.legal  = 1'b1; dec.use1 = 1'b1; dec.use2 = 1'b1;
        dec.mem_wr = 1'b1; dec.b    = 2'b01;
      end
      OP_BR: begin
        dec.legal = 1'b1; dec.use1 = 1'b1; dec.use2 = 1'b1;
        dec.br    = 1'b1; dec.alu  = 2'b01;
      end
      OP_JAL: begin
        if (SUPPORT_UJ != 0) begin
          dec.legal = 1'b1; dec.rd_we = 1'b1; dec.jmp = 1'b1;
          dec.a     = 2'b01; dec.b    = 2'b10; dec.data = 2'b10;
        end
      end
      OP_JALR: begin
        if (SUPPORT_UJ != 0) begin
          dec.legal = 1'b1; dec.use1 = 1'b1;
          dec.rd_we = 1'b1; dec.jmp  = 1'b1;
          dec.b     = 2'b01; dec.data = 2'b10;
        end
      end
      OP_LUI: begin
        if (SUPPORT_UJ != 0) begin
          dec.legal = 1'b1; dec.rd_we = 1'b1;
          dec.a     = 2'b10; dec.b    = 2'b01;
        end
      end
      OP_AUIPC: begin
        if (SUPPORT_UJ != 0) begin
          dec.legal = 1'b1; dec.rd_we = 1'b1;
          dec.a     = 2'b01; dec.b    = 2'b01;
        end
      end
      default: dec = '0;
    endcase
  end

  // Load-use hazard: a load in ID/EX writes a register this instruction reads.
  always_comb begin
    hazard = (state == RUN) && instr_valid && idex.valid && idex.mem_rd &&
             (idex.rd != 5'd0) &&
             ((dec.use1 && (rs1_f == idex.rd)) ||
              (dec.use2 && (rs2_f == idex.rd)));
  end

  // IF/ID hold request; forced low while reset is asserted.
  always_comb begin
    stall = rst && (hazard || (state == STALL) || !ex_ready);
  end

  // Value the ID/EX register takes on an accepted edge: a real decode only
  // in RUN with no flush and no hazard, otherwise a bubble. An unsupported
  // valid opcode becomes a bubble carrying the illegal flag.
  always_comb begin
    nxt = '0;
    if ((state == RUN) && !flush && !hazard) begin
      if (instr_valid && dec.legal) begin
        nxt.valid  = 1'b1;
        nxt.rd_we  = dec.rd_we;
        nxt.mem_rd = dec.mem_rd;
        nxt.mem_wr = dec.mem_wr;
        nxt.br     = dec.br;
        nxt.jmp    = dec.jmp;
        nxt.alu    = dec.alu;
        nxt.a      = dec.a;
        nxt.b      = dec.b;
        nxt.data   = dec.data;
        nxt.rd     = dec.rd_we ? rd_f : 5'd0;
      end else begin
        nxt.illegal = instr_valid;
      end
    end
  end

  // RUN/STALL controller and ID/EX register, advancing only when EX accepts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      cnt   <= 2'd0;
      idex  <= '0;
    end else if (ex_ready) begin
      idex <= nxt;
      if (state == RUN) begin
        if (!flush && hazard && (LOAD_USE_STALLS > 1)) begin
          state <= STALL;
          cnt   <= CNT_INIT;
        end
      end else begin
        if (flush) begin
          state <= RUN;
          cnt   <= 2'd0;
        end else begin
          cnt <= cnt - 2'd1;
          if (cnt == 2'd1) begin
            state <= RUN;
          end
        end
      end
    end
  end

  // Output mapping from the ID/EX register; upper alu_ctrl bits stay zero.
  always_comb begin
    ex_valid      = idex.valid;
    mem_read_en   = idex.mem_rd;
    mem_write_en  = idex.mem_wr;
    reg_write_en  = idex.rd_we;
    branch_flag   = idex.br;
    jump_flag     = idex.jmp;
    alu_ctrl      = '0;
    alu_ctrl[1:0] = idex.alu;
    mux_a_sel     = idex.a;
    mux_b_sel     = idex.b;
    mux_data_sel  = idex.data;
    rd_out        = idex.rd;
    illegal_op    = idex.illegal;
    state_dbg     = (state == STALL);
    cnt_dbg       = cnt;
  end

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 Parameter ALU_CTRL_W, default 2; alu_ctrl width, legal range 2..4, bits above [1:0] driven 0.
REQ-002 Parameter LOAD_USE_STALLS, default 1; bubbles inserted per load-use hazard, legal range 1..3.
REQ-003 Parameter SUPPORT_UJ, default 1; 1 decodes JAL/JALR/LUI/AUIPC, 0 treats them as illegal.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset; asynchronous and active-low.
REQ-006 instr_valid  in  1  instr holds a valid ID-stage instruction.
REQ-007 instr  in  32  RV32 instruction: opcode [6:0], rd [11:7], rs1 [19:15], rs2 [24:20].
REQ-008 ex_ready  in  1  EX stage accepts the ID/EX register this cycle.
REQ-009 flush  in  1  branch/jump taken in EX; squash the ID instruction.
REQ-010 ex_valid  out  1  ID/EX register holds a real instruction, not a bubble.
REQ-011 mem_read_en, mem_write_en, reg_write_en, branch_flag, jump_flag  out  1 each  registered control bits.
REQ-012 alu_ctrl  out  ALU_CTRL_W  00 add, 01 sub/compare, 10 R-type funct decode, 11 I-type funct decode.
REQ-013 mux_a_sel  out  2  00 rs1, 01 PC, 10 zero.
REQ-014 mux_b_sel  out  2  00 rs2, 01 immediate, 10 constant 4.
REQ-015 mux_data_sel  out  2  writeback source: 00 ALU, 01 memory, 10 PC+4.
REQ-016 rd_out  out  5  registered destination register.
REQ-017 stall  out  1  combinational; IF/ID must hold its instruction.
REQ-018 illegal_op  out  1  registered; a valid instruction with an unsupported opcode was decoded.

Function
REQ-019 Decode (rd_we, mem_rd, mem_wr, br, jmp, alu, a, b, data):
- R 0110011: 1,0,0,0,0, 10, 00, 00, 00.
- I-ALU 0010011: 1,0,0,0,0, 11, 00, 01, 00.
- LOAD 0000011: 1,1,0,0,0, 00, 00, 01, 01.
- STORE 0100011: 0,0,1,0,0, 00, 00, 01, 00.
- BRANCH 1100011: 0,0,0,1,0, 01, 00, 00, 00.
- JAL 1101111: 1,0,0,0,1, 00, 01, 10, 10.
- JALR 1100111: 1,0,0,0,1, 00, 00, 01, 10.
- LUI 0110111: 1,0,0,0,0, 00, 10, 01, 00.
- AUIPC 0010111: 1,0,0,0,0, 00, 01, 01, 00.
REQ-020 Bubble: all control outputs 0, rd_out 0, ex_valid 0, illegal_op 0.
REQ-021 Unsupported opcode with instr_valid=1 loads a bubble with illegal_op=1 for one cycle.
REQ-022 Latency: decoded values appear on outputs one clock after capture.
REQ-023 Source usage: rs1 is used by all opcodes except LUI, AUIPC and JAL; rs2 is used by R, STORE and BRANCH.
REQ-024 hazard = state RUN, instr_valid, ex_valid, mem_read_en, rd_out != 0, and a used rs1 or rs2 equal to rd_out.
REQ-025 FSM has two states, RUN and STALL, plus a 2-bit counter cnt.
REQ-026 stall = hazard | (state == STALL) | !ex_ready.
REQ-027 ex_ready=0: ID/EX register, state and cnt hold; flush is ignored.
REQ-028 RUN, ex_ready=1, flush=1: capture a bubble; state stays RUN.
REQ-029 RUN, ex_ready=1, hazard, flush=0: capture a bubble; if LOAD_USE_STALLS > 1, go to STALL with cnt = LOAD_USE_STALLS-1.
REQ-030 RUN, ex_ready=1, no hazard, no flush: capture the decode of instr, or a bubble if instr_valid=0.
REQ-031 STALL, ex_ready=1: capture a bubble; decrement cnt; return to RUN when cnt == 1.
REQ-032 STALL with flush=1: return to RUN immediately, cnt=0; flush takes priority over the hazard.
REQ-033 rd=0 loads never cause a hazard.

Reset
REQ-034 While rst=0: all outputs 0, state RUN, cnt 0, asynchronously, independent of clk.
REQ-035 Reset asserted mid-stall abandons the stall; the first edge after release decodes normally.

Verification
REQ-036 LW x5 then ADD x6,x5,x7, LOAD_USE_STALLS=1: stall=1 for one cycle; one bubble (ex_valid=0); ADD then issues with reg_write_en=1, alu_ctrl=10.
REQ-037 Same sequence with LOAD_USE_STALLS=3: exactly three consecutive bubbles; stall high three cycles.
REQ-038 LW x0 then ADD x6,x0,x0: no stall; back-to-back issue.
REQ-039 Hazard cycle with flush=1: bubble, state RUN, stall falls next cycle.
REQ-040 ex_ready=0 for 2 cycles during STALL: outputs and cnt frozen; remaining bubbles complete after ex_ready returns.
REQ-041 JAL with SUPPORT_UJ=0: bubble, illegal_op=1 for one cycle. Reset pulsed mid-stall: all outputs 0 immediately.
